// File: rtl/ff_bank.sv
// Bank of W run-time selectable SR/JK/D/T flip-flops with change flags,
// per-channel sticky illegal-SR flags and a saturating illegal-cycle counter.
module ff_bank #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}},
   parameter int             SR_PRIO = 0,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             err_clr,
   output logic [W-1:0]     q,
   output logic [W-1:0]     q_bar,
   output logic [W-1:0]     changed,
   output logic [W-1:0]     err_sticky,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [1:0] MODE_SR = 2'b00;
   localparam logic [1:0] MODE_JK = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_T  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [W-1:0]     q_reg;
   logic [W-1:0]     q_next;
   logic [W-1:0]     changed_reg;
   logic [W-1:0]     sticky_reg;
   logic [W-1:0]     illegal;
   logic [CNT_W-1:0] cnt_reg;
   logic             any_illegal;

   for (genvar gi = 0; gi < W; gi++) begin : g_ch
      logic nq;

      always_comb begin
         nq = q_reg[gi];
         if (en) begin
            case (mode)
               MODE_SR: begin
                  case ({a[gi], b[gi]})
                     2'b01:   nq = 1'b0;
                     2'b10:   nq = 1'b1;
                     2'b11: begin
                        // S=R=1 resolved by the configured policy rather than going X
                        if (SR_PRIO == 1)      nq = 1'b1;
                        else if (SR_PRIO == 2) nq = 1'b0;
                        else                   nq = q_reg[gi];
                     end
                     default: nq = q_reg[gi];
                  endcase
               end
               MODE_JK: begin
                  case ({a[gi], b[gi]})
                     2'b01:   nq = 1'b0;
                     2'b10:   nq = 1'b1;
                     2'b11:   nq = ~q_reg[gi];
                     default: nq = q_reg[gi];
                  endcase
               end
               MODE_D:  nq = a[gi];
               MODE_T:  nq = q_reg[gi] ^ a[gi];
               default: nq = q_reg[gi];
            endcase
         end
      end

      assign q_next[gi]  = nq;
      assign illegal[gi] = en && (mode == MODE_SR) && a[gi] && b[gi];
   end

   assign any_illegal = |illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg       <= RST_VAL;
         changed_reg <= '0;
         sticky_reg  <= '0;
         cnt_reg     <= '0;
      end else begin
         q_reg       <= q_next;
         // q_next equals q_reg whenever en=0, so changed clears itself
         changed_reg <= q_next ^ q_reg;
         if (err_clr) begin
            sticky_reg <= illegal;
            cnt_reg    <= {{(CNT_W-1){1'b0}}, any_illegal};
         end else begin
            sticky_reg <= sticky_reg | illegal;
            if (any_illegal && (cnt_reg != CNT_MAX))
               cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign q          = q_reg;
   assign q_bar      = ~q_reg;
   assign changed    = changed_reg;
   assign err_sticky = sticky_reg;
   assign err_cnt    = cnt_reg;

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of W edge-triggered storage bits, each behaving as an SR, JK, D or T flip-flop, selected at run time by a shared mode input. It replaces the single-bit fixed-function flip-flop with a defined policy for the SR S=R=1 case in place of an X output. It also detects and records illegal input combinations and reports per-bit change events. It is used as the general-purpose state element in the flip-flop experiment suite and in small control datapaths.

## Interface

Parameters:
- W, 8, number of flip-flop channels (≥1)
- RST_VAL, {W{1'b0}}, value loaded into q on reset
- SR_PRIO, 0, SR-mode S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant
- CNT_W, 8, width of saturating illegal-event counter (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  update enable; low means every channel holds
- mode  in  2  00 SR, 01 JK, 10 D, 11 T; shared by all channels
- a  in  W  per-channel S / J / D / T input
- b  in  W  per-channel R / K input; ignored in D and T modes
- err_clr  in  1  clears err_sticky and err_cnt
- q  out  W  registered state
- q_bar  out  W  ~q, combinational from the q register
- changed  out  W  registered; bit i is 1 for the cycle after q[i] changed value
- err_sticky  out  W  bit i is set when channel i saw S=R=1 in SR mode with en=1
- err_cnt  out  CNT_W  count of cycles with any illegal channel; saturates at all-ones

## Operation

- Next state per channel i, when en=1:
  - SR mode, (a,b):
    - 00 → hold
    - 01 → 0
    - 10 → 1
    - 11 → per SR_PRIO: hold, 1 or 0
  - JK mode, (a,b):
    - 00 → hold
    - 01 → 0
    - 10 → 1
    - 11 → ~q
  - D mode: q ← a[i].
  - T mode: q ← q ^ a[i].
- en=0: q holds, changed ← 0, no illegal detection, err_cnt unchanged.
- Illegal event: en=1, mode=00, a[i]&b[i]=1. Only SR mode is illegal; JK 11 is legal.
- err_sticky[i] ← 1 on an illegal event in channel i.
- err_cnt increments by 1 per cycle in which any channel is illegal, regardless of how many channels. It holds at 2^CNT_W−1.
- err_clr=1:
  - err_sticky ← current-cycle illegal vector (0 if none).
  - err_cnt ← 1 if any channel is illegal this cycle, else 0.
  - A new event in the same cycle therefore wins over the clear.
- changed ← q_next ^ q every cycle, with en gating applied as above.
- A mode change takes effect on the edge where the new mode is sampled. No state is lost: q carries over unchanged.
- rst=1 overrides all inputs:
  - q ← RST_VAL
  - changed ← 0
  - err_sticky ← 0
  - err_cnt ← 0
- An illegal condition present in the reset cycle is not recorded.

## Timing

- All outputs are registered except q_bar, which is a direct inverter on q.
- Latency: inputs sampled at edge k appear on q, changed, err_sticky and err_cnt immediately after edge k (one-cycle update).
- Reset values:
  - q = RST_VAL
  - q_bar = ~RST_VAL
  - changed = 0
  - err_sticky = 0
  - err_cnt = 0
- Reset asserted mid-operation takes effect at the next edge. The cycle after rst deasserts behaves as a normal cycle.
- No combinational path from any input to any output.
- All channels update in the same cycle. There is no inter-channel dependency.

## Test plan

- Reset, W=4, RST_VAL=4'b1010, rst=1 for 2 cycles → q=1010, q_bar=0101, changed=0, err_sticky=0, err_cnt=0.
- SR mode, from q=0000:
  - a=0011, b=0100 → q=0011, changed=0011.
  - Then a=0000, b=0001 → q=0010, changed=0001.
- SR illegal, SR_PRIO=1, from q=0000:
  - a=b=1001 for 3 cycles → q=1001, err_sticky=1001, err_cnt=3.
  - With CNT_W=2, after 5 illegal cycles err_cnt=3 (saturated).
- JK and T toggle, from q=0101:
  - JK with a=b=1111 → q=1010, err_sticky unchanged.
  - Then T with a=0011 → q=1001.
- en gating and D mode, from q=1001:
  - en=0, D mode, a=0110 → q=1001, changed=0.
  - en=1 → q=0110, changed=1111.
- Clear vs. event, from err_sticky=1001, err_cnt=2, SR mode:
  - err_clr=1 with a=b=0100 → err_sticky=0100, err_cnt=1.
  - err_clr=1 with a=b=0 → err_sticky=0000, err_cnt=0.
  - rst mid-sequence → all outputs return to reset values next cycle.
